// File: rtl/m68k_bus_master_if.sv
// Host request/response and 68000 bus signals of the bus-cycle initiator.
// master = the initiator's view; slave = host plus responder side.
interface m68k_bus_master_if;
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 3;

  logic          req;
  logic [AW-1:0] addr;
  logic          we;
  logic          ube;
  logic          lbe;
  logic [FW-1:0] fc;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          ack;
  logic          berr;
  logic [DW-1:0] rdata;

  logic [AW-1:0] A;
  logic [FW-1:0] FC;
  logic          AS_N;
  logic          UDS_N;
  logic          LDS_N;
  logic          RW;
  logic [DW-1:0] DOUT;
  logic          DOUT_OE;
  logic [DW-1:0] DIN;
  logic          DTACK_N;
  logic          BERR_N;

  modport master (
    input  req, addr, we, ube, lbe, fc, wdata, DIN, DTACK_N, BERR_N,
    output busy, ack, berr, rdata, A, FC, AS_N, UDS_N, LDS_N, RW, DOUT, DOUT_OE
  );

  modport slave (
    output req, addr, we, ube, lbe, fc, wdata, DIN, DTACK_N, BERR_N,
    input  busy, ack, berr, rdata, A, FC, AS_N, UDS_N, LDS_N, RW, DOUT, DOUT_OE
  );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000 bus-cycle initiator: turns host word/byte requests into AS/UDS/LDS/RW
// sequences paced by the 8 MHz enables, ending on DTACK_N, BERR_N or timeout.
module m68k_bus_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              mhz8_en1,
  input  logic              mhz8_en2,
  input  logic              bus_free,
  m68k_bus_master_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 3;

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S4W, S5, S6, S7
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          err_flag, err_flag_nxt;
  logic          cyc_we, cyc_we_nxt;
  logic          cyc_ube, cyc_ube_nxt;
  logic          cyc_lbe, cyc_lbe_nxt;
  logic          busy_r, busy_nxt;
  logic          ack_r, ack_nxt;
  logic          berr_r, berr_nxt;
  logic [DW-1:0] rdata_r, rdata_nxt;
  logic [AW-1:0] a_r, a_nxt;
  logic [FW-1:0] fc_r, fc_nxt;
  logic          as_n_r, as_n_nxt;
  logic          uds_n_r, uds_n_nxt;
  logic          lds_n_r, lds_n_nxt;
  logic          rw_r, rw_nxt;
  logic [DW-1:0] dout_r, dout_nxt;
  logic          dout_oe_r, dout_oe_nxt;
  logic          en1, en2;

  // Coincident enables are a clocking fault; treat that clk32 as having no edge.
  assign en1 = mhz8_en1 & ~mhz8_en2;
  assign en2 = mhz8_en2 & ~mhz8_en1;

  // State and registered outputs
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      err_flag  <= 1'b0;
      cyc_we    <= 1'b0;
      cyc_ube   <= 1'b0;
      cyc_lbe   <= 1'b0;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      berr_r    <= 1'b0;
      rdata_r   <= '0;
      a_r       <= '0;
      fc_r      <= '0;
      as_n_r    <= 1'b1;
      uds_n_r   <= 1'b1;
      lds_n_r   <= 1'b1;
      rw_r      <= 1'b1;
      dout_r    <= '0;
      dout_oe_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      err_flag  <= err_flag_nxt;
      cyc_we    <= cyc_we_nxt;
      cyc_ube   <= cyc_ube_nxt;
      cyc_lbe   <= cyc_lbe_nxt;
      busy_r    <= busy_nxt;
      ack_r     <= ack_nxt;
      berr_r    <= berr_nxt;
      rdata_r   <= rdata_nxt;
      a_r       <= a_nxt;
      fc_r      <= fc_nxt;
      as_n_r    <= as_n_nxt;
      uds_n_r   <= uds_n_nxt;
      lds_n_r   <= lds_n_nxt;
      rw_r      <= rw_nxt;
      dout_r    <= dout_nxt;
      dout_oe_r <= dout_oe_nxt;
    end
  end

  // Bus-cycle sequencing: even half-states start on en1, odd ones on en2
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_flag_nxt = err_flag;
    cyc_we_nxt   = cyc_we;
    cyc_ube_nxt  = cyc_ube;
    cyc_lbe_nxt  = cyc_lbe;
    busy_nxt     = busy_r;
    ack_nxt      = 1'b0;
    berr_nxt     = 1'b0;
    rdata_nxt    = rdata_r;
    a_nxt        = a_r;
    fc_nxt       = fc_r;
    as_n_nxt     = as_n_r;
    uds_n_nxt    = uds_n_r;
    lds_n_nxt    = lds_n_r;
    rw_nxt       = rw_r;
    dout_nxt     = dout_r;
    dout_oe_nxt  = dout_oe_r;

    unique case (state)
      IDLE: begin
        if (en1 && bus.req && !busy_r && bus_free) begin
          state_nxt    = S0;
          cyc_we_nxt   = bus.we;
          cyc_ube_nxt  = bus.ube;
          cyc_lbe_nxt  = bus.lbe;
          err_flag_nxt = 1'b0;
          busy_nxt     = 1'b1;
          rw_nxt       = ~bus.we;
          fc_nxt       = bus.fc;
          a_nxt        = bus.addr;
          dout_nxt     = bus.wdata;
        end
      end
      S0: if (en2) state_nxt = S1;
      S1: begin
        if (en1) begin
          state_nxt = S2;
          as_n_nxt  = 1'b0;
          if (!cyc_we) begin
            uds_n_nxt = ~cyc_ube;
            lds_n_nxt = ~cyc_lbe;
          end
        end
      end
      S2: begin
        if (en2) begin
          state_nxt   = S3;
          dout_oe_nxt = cyc_we;
        end
      end
      S3: begin
        if (en1) begin
          state_nxt = S4;
          if (cyc_we) begin
            uds_n_nxt = ~cyc_ube;
            lds_n_nxt = ~cyc_lbe;
          end
        end
      end
      // Termination sample; BERR_N wins over DTACK_N, the counter saturates at TIMEOUT
      S4, S4W: begin
        if (en2) begin
          if (!bus.BERR_N) begin
            err_flag_nxt = 1'b1;
            state_nxt    = S5;
          end else if (!bus.DTACK_N) begin
            state_nxt    = S5;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            err_flag_nxt = 1'b1;
            state_nxt    = S5;
          end else begin
            wait_cnt_nxt = wait_cnt + CW'(1);
            state_nxt    = S4W;
          end
        end
      end
      S5: if (en1) state_nxt = S6;
      S6: begin
        if (en2) begin
          state_nxt = S7;
          if (!cyc_we && !err_flag) rdata_nxt = bus.DIN;
          as_n_nxt  = 1'b1;
          uds_n_nxt = 1'b1;
          lds_n_nxt = 1'b1;
        end
      end
      S7: begin
        if (en1) begin
          state_nxt    = IDLE;
          rw_nxt       = 1'b1;
          dout_oe_nxt  = 1'b0;
          busy_nxt     = 1'b0;
          ack_nxt      = 1'b1;
          berr_nxt     = err_flag;
          wait_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy    = busy_r;
  assign bus.ack     = ack_r;
  assign bus.berr    = berr_r;
  assign bus.rdata   = rdata_r;
  assign bus.A       = a_r;
  assign bus.FC      = fc_r;
  assign bus.AS_N    = as_n_r;
  assign bus.UDS_N   = uds_n_r;
  assign bus.LDS_N   = lds_n_r;
  assign bus.RW      = rw_r;
  assign bus.DOUT    = dout_r;
  assign bus.DOUT_OE = dout_oe_r;
endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: timeline model of each bus cycle checked every clk32,
// plus directed transactions with hand-computed strobe widths and latencies.
`timescale 1ns/1ps
module tb_m68k_bus_master;
  localparam int unsigned TO = 4;

  logic clk32    = 1'b0;
  logic reset    = 1'b1;
  logic mhz8_en1 = 1'b0;
  logic mhz8_en2 = 1'b0;
  logic bus_free = 1'b1;
  bit   force_both = 1'b0;
  bit   run = 1'b0;
  int   ph = 0;

  int n_vec = 0;
  int n_bad = 0;
  int c_busy = 0, c_as = 0, c_uds = 0, c_lds = 0, c_oe = 0, c_rw = 0, c_ack = 0;

  m68k_bus_master_if bus();

  m68k_bus_master #(.TIMEOUT(TO)) dut (
    .clk32    (clk32),
    .reset    (reset),
    .mhz8_en1 (mhz8_en1),
    .mhz8_en2 (mhz8_en2),
    .bus_free (bus_free),
    .bus      (bus)
  );

  always #5 clk32 = ~clk32;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // 8 MHz enables: en1 every 4 clk32, en2 two clk32 later; optional coincident pulse
  initial begin
    forever begin
      @(posedge clk32);
      #2;
      ph = (ph + 1) % 4;
      mhz8_en1 = (ph == 0);
      mhz8_en2 = (ph == 2) || (ph == 0 && force_both);
      if (ph == 0) force_both = 1'b0;
    end
  end

  // Model: a cycle is a timeline in clk32 counted from the capture edge (t=0).
  // Termination is sampled at t=10,14,18..; strobes rise 4 after it, ack 6 after it.
  bit          m_active, m_done, m_err, m_we, m_ube, m_lbe, m_ack, m_berr;
  int          m_t, m_t5, m_waits, m_next;
  logic [22:0] m_A;
  logic [2:0]  m_FC;
  logic [15:0] m_DOUT, m_rdata;

  always @(posedge clk32 or posedge reset) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_err = 0; m_ack = 0; m_berr = 0; m_t = 0;
      m_A = '0; m_FC = '0; m_DOUT = '0; m_rdata = '0;
    end else begin
      m_ack = 0;
      m_berr = 0;
      if (m_active) begin
        m_t++;
        if (!m_done && m_t == m_next) begin
          if (!bus.BERR_N) begin m_err = 1; m_done = 1; m_t5 = m_t; end
          else if (!bus.DTACK_N) begin m_done = 1; m_t5 = m_t; end
          else if (m_waits == int'(TO)) begin m_err = 1; m_done = 1; m_t5 = m_t; end
          else begin m_waits++; m_next += 4; end
        end
        if (m_done && m_t == m_t5 + 4 && !m_we && !m_err) m_rdata = bus.DIN;
        if (m_done && m_t == m_t5 + 6) begin
          m_active = 0; m_ack = 1; m_berr = m_err;
        end
      end else if (mhz8_en1 && !mhz8_en2 && bus.req && bus_free) begin
        m_active = 1; m_done = 0; m_err = 0; m_t = 0; m_waits = 0; m_next = 10;
        m_we = bus.we; m_ube = bus.ube; m_lbe = bus.lbe;
        m_A = bus.addr; m_FC = bus.fc; m_DOUT = bus.wdata;
      end
    end
  end

  bit       e_win, e_as, e_uds, e_lds;
  logic [7:0] e_ctl;

  // Every-cycle compare of the DUT against the model
  always @(negedge clk32) begin
    if (run) begin
      e_win = m_active && !(m_done && m_t >= m_t5 + 4);
      e_as  = e_win && m_t >= 4;
      e_uds = e_win && m_ube && m_t >= (m_we ? 8 : 4);
      e_lds = e_win && m_lbe && m_t >= (m_we ? 8 : 4);
      e_ctl = {m_active, m_ack, m_berr, !e_as, !e_uds, !e_lds,
               !(m_active && m_we), m_active && m_we && m_t >= 6};
      check("ctl", 64'({bus.busy, bus.ack, bus.berr, bus.AS_N, bus.UDS_N, bus.LDS_N,
                        bus.RW, bus.DOUT_OE}), 64'(e_ctl));
      check("data", 64'({bus.A, bus.FC, bus.DOUT, bus.rdata}),
            64'({m_A, m_FC, m_DOUT, m_rdata}));
    end
  end

  // Strobe-width measurement for the hand-computed checks
  always @(negedge clk32) begin
    if (bus.busy === 1'b1)    c_busy++;
    if (bus.AS_N === 1'b0)    c_as++;
    if (bus.UDS_N === 1'b0)   c_uds++;
    if (bus.LDS_N === 1'b0)   c_lds++;
    if (bus.DOUT_OE === 1'b1) c_oe++;
    if (bus.RW === 1'b0)      c_rw++;
    if (bus.ack === 1'b1)     c_ack++;
  end

  task automatic clr_counts();
    c_busy = 0; c_as = 0; c_uds = 0; c_lds = 0; c_oe = 0; c_rw = 0; c_ack = 0;
  endtask

  task automatic start_txn(input bit we, input bit ube, input bit lbe, input logic [22:0] addr,
                           input logic [2:0] fc, input logic [15:0] wdata, input logic [15:0] din,
                           input int dtack_at, input bit berr_low);
    bus.we = we; bus.ube = ube; bus.lbe = lbe; bus.addr = addr; bus.fc = fc;
    bus.wdata = wdata; bus.DIN = din;
    bus.DTACK_N = (dtack_at == 0) ? 1'b0 : 1'b1;
    bus.BERR_N = ~berr_low;
    clr_counts();
    bus.req = 1'b1;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy !== 1'b1 && n < 200) begin
      @(negedge clk32);
      n++;
    end
    if (bus.busy !== 1'b1) check("busy_wait", 64'(bus.busy), 64'd1);
  endtask

  task automatic finish_txn(input int dtack_at, output bit eb);
    int k;
    k = 0;
    while (bus.ack !== 1'b1 && k < 400) begin
      @(negedge clk32);
      k++;
      if (k == dtack_at) bus.DTACK_N = 1'b0;
    end
    if (bus.ack !== 1'b1) check("ack_wait", 64'(bus.ack), 64'd1);
    eb = bus.berr;
    bus.req = 1'b0;
    bus.DTACK_N = 1'b1;
    bus.BERR_N = 1'b1;
  endtask

  // Leaves the bench one negedge after an en1 edge: next en1 edge is 4 clk32 away
  task automatic align_en1();
    int g;
    g = 0;
    while (mhz8_en1 !== 1'b1 && g < 8) begin
      @(negedge clk32);
      g++;
    end
    @(negedge clk32);
  endtask

  initial begin
    int n;
    bit eb;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit eb;
    bus.req = 0; bus.addr = '0; bus.we = 0; bus.ube = 0; bus.lbe = 0; bus.fc = '0;
    bus.wdata = '0; bus.DIN = '0; bus.DTACK_N = 1; bus.BERR_N = 1;
    repeat (3) @(negedge clk32);
    #1 reset = 1'b0;
    @(negedge clk32);
    run = 1'b1;

    check("rst_ctl", 64'({bus.busy, bus.ack, bus.berr, bus.AS_N, bus.UDS_N, bus.LDS_N,
                          bus.RW, bus.DOUT_OE}), 64'h1E);
    check("rst_data", 64'({bus.A, bus.FC, bus.DOUT, bus.rdata}), 64'd0);

    // Zero-wait word read
    start_txn(0, 1, 1, 23'h7FFFF, 3'd5, 16'h0000, 16'h1234, 0, 0);
    wait_busy(n);
    finish_txn(0, eb);
    check("rd_lat", 64'(c_busy), 64'd16);
    check("rd_as_low", 64'(c_as), 64'd10);
    check("rd_uds_low", 64'(c_uds), 64'd10);
    check("rd_lds_low", 64'(c_lds), 64'd10);
    check("rd_rdata", 64'(bus.rdata), 64'h1234);
    check("rd_berr", 64'(eb), 64'd0);

    // Lower-byte write, issued straight after the previous ack
    start_txn(1, 0, 1, 23'h12345, 3'd1, 16'h00A5, 16'hFFFF, 0, 0);
    wait_busy(n);
    check("b2b_capture", 64'(n), 64'd4);
    finish_txn(0, eb);
    check("wr_lat", 64'(c_busy), 64'd16);
    check("wr_uds_low", 64'(c_uds), 64'd0);
    check("wr_lds_low", 64'(c_lds), 64'd6);
    check("wr_oe_high", 64'(c_oe), 64'd10);
    check("wr_rw_low", 64'(c_rw), 64'd16);
    check("wr_dout", 64'(bus.DOUT), 64'h00A5);
    check("wr_rdata_kept", 64'(bus.rdata), 64'h1234);

    // DTACK three 8 MHz periods late
    start_txn(0, 1, 1, 23'h00100, 3'd6, 16'h0, 16'hBEEF, 20, 0);
    wait_busy(n);
    finish_txn(20, eb);
    check("wait3_lat", 64'(c_busy), 64'd28);
    check("wait3_as_low", 64'(c_as), 64'd22);
    check("wait3_rdata", 64'(bus.rdata), 64'hBEEF);
    check("wait3_berr", 64'(eb), 64'd0);

    // DTACK just after the first sample point
    start_txn(0, 1, 0, 23'h00200, 3'd2, 16'h0, 16'h0F0F, 10, 0);
    wait_busy(n);
    finish_txn(10, eb);
    check("late1_lat", 64'(c_busy), 64'd20);
    check("late1_rdata", 64'(bus.rdata), 64'h0F0F);

    // No termination at all: internal timeout
    start_txn(0, 1, 1, 23'h00300, 3'd5, 16'h0, 16'h5555, -1, 0);
    wait_busy(n);
    finish_txn(-1, eb);
    check("tmo_lat", 64'(c_busy), 64'd32);
    check("tmo_berr", 64'(eb), 64'd1);
    check("tmo_rdata", 64'(bus.rdata), 64'h0F0F);

    // BERR only
    start_txn(0, 1, 1, 23'h00400, 3'd5, 16'h0, 16'h6666, -1, 1);
    wait_busy(n);
    finish_txn(-1, eb);
    check("berr_lat", 64'(c_busy), 64'd16);
    check("berr_flag", 64'(eb), 64'd1);

    // DTACK and BERR together
    start_txn(0, 1, 1, 23'h00500, 3'd5, 16'h0, 16'hAAAA, 0, 1);
    wait_busy(n);
    finish_txn(0, eb);
    check("both_berr", 64'(eb), 64'd1);
    check("both_rdata", 64'(bus.rdata), 64'h0F0F);

    // Upper-byte write
    start_txn(1, 1, 0, 23'h7FFFFF, 3'd1, 16'h5A00, 16'h0, 0, 0);
    wait_busy(n);
    finish_txn(0, eb);
    check("wru_uds_low", 64'(c_uds), 64'd6);
    check("wru_lds_low", 64'(c_lds), 64'd0);
    check("wru_berr", 64'(eb), 64'd0);

    // Bus owned by another master
    bus_free = 1'b0;
    start_txn(0, 1, 1, 23'h00600, 3'd5, 16'h0, 16'h1111, 0, 0);
    repeat (24) @(negedge clk32);
    check("nofree_as", 64'(c_as), 64'd0);
    check("nofree_busy", 64'(c_busy), 64'd0);
    align_en1();
    bus_free = 1'b1;
    wait_busy(n);
    check("free_capture", 64'(n), 64'd4);
    finish_txn(0, eb);
    check("free_rdata", 64'(bus.rdata), 64'h1111);

    // Coincident enables at the first en1 after the request
    align_en1();
    start_txn(0, 1, 1, 23'h00700, 3'd5, 16'h0, 16'h2222, 0, 0);
    force_both = 1'b1;
    wait_busy(n);
    check("coincident_capture", 64'(n), 64'd8);
    finish_txn(0, eb);

    // Reset while in S5
    start_txn(0, 1, 1, 23'h00800, 3'd5, 16'h0, 16'h7777, 0, 0);
    wait_busy(n);
    repeat (11) @(negedge clk32);
    check("pre_rst_as", 64'(bus.AS_N), 64'd0);
    #1 reset = 1'b1;
    bus.req = 1'b0;
    c_ack = 0;
    #1 check("rst_strobes", 64'({bus.AS_N, bus.UDS_N, bus.LDS_N, bus.DOUT_OE, bus.busy}),
             64'(5'b11100));
    @(negedge clk32);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk32);
    check("rst_no_ack", 64'(c_ack), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);

    // Next request after reset
    start_txn(0, 1, 1, 23'h00900, 3'd5, 16'h0, 16'h3C3C, 0, 0);
    wait_busy(n);
    finish_txn(0, eb);
    check("post_rst_lat", 64'(c_busy), 64'd16);
    check("post_rst_rdata", 64'(bus.rdata), 64'h3C3C);
    check("post_rst_berr", 64'(eb), 64'd0);

    repeat (4) @(negedge clk32);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/m68k_bus_master.md
# m68k_bus_master

Cycle-accurate 68000 bus-cycle initiator for the STE core. It accepts simple word or byte read/write requests from a host-side controller (debug loader, test sequencer, or CPU-less bring-up harness) and turns them into AS_N/UDS_N/LDS_N/RW strobe sequences. Each sequence is timed by the GSTMCU 8 MHz enables. It terminates on DTACK_N or BERR_N from the responder side (gstmcu/shifter/DMA), which makes it the initiator end of the bus that gstmcu decodes.

## Interface
- TIMEOUT, 64: number of wait-state pairs (full 8 MHz periods in S4) before an internal bus error.
- clk32  in  1  system clock, 32 MHz.
- reset  in  1  asynchronous, active-high reset.
- mhz8_en1  in  1  one-clk32 pulse at the MHZ8 rising edge.
- mhz8_en2  in  1  one-clk32 pulse at the MHZ8 falling edge.
- bus_free  in  1  high when no other master owns the bus.
- req  in  1  request, level; held until ack.
- addr  in  23  word address [23:1].
- we  in  1  1 = write, 0 = read.
- ube, lbe  in  1 each  upper/lower byte enables; at least one set.
- fc  in  3  function code for the cycle.
- wdata  in  16  write data.
- busy  out  1  request captured, cycle in progress.
- ack  out  1  one-clk32 completion pulse.
- berr  out  1  qualifies ack: cycle ended by bus error or timeout.
- rdata  out  16  read data, valid from ack until the next capture.
- A  out  23  bus address.
- FC  out  3  bus function code.
- AS_N, UDS_N, LDS_N  out  1 each  bus strobes.
- RW  out  1  1 = read.
- DOUT  out  16  write data to the bus.
- DOUT_OE  out  1  data bus drive enable.
- DIN  in  16  read data from the bus.
- DTACK_N, BERR_N  in  1 each  cycle termination from the responder.

## Operation
- States: IDLE, S0–S7, plus S4W, a wait pair inside S4. Even states begin on mhz8_en1 and odd states on mhz8_en2. No state advances on any other clk32 edge.
- IDLE → S0: on mhz8_en1 with req=1, busy=0 and bus_free=1. At that edge:
  - addr, we, ube, lbe, fc and wdata are latched.
  - busy←1.
  - RW←~we, FC←fc, A←addr, DOUT←wdata.
- S1→S2 (en1): AS_N←0. For a read, UDS_N←~ube and LDS_N←~lbe.
- S2→S3 (en2): DOUT_OE←we.
- S3→S4 (en1): for a write, UDS_N←~ube and LDS_N←~lbe.
- S4→S5 (en2): DTACK_N and BERR_N are sampled.
  - BERR_N=0 takes priority: flag error, continue to S5.
  - DTACK_N=0: continue to S5.
  - Neither asserted: go to S4W, increment the wait counter, and re-sample on each later en2.
  - Wait counter reaches TIMEOUT: flag error, continue to S5.
- S6→S7 (en2): for a read, rdata←DIN; an errored cycle leaves rdata unchanged. AS_N, UDS_N and LDS_N ←1.
- S7→IDLE (en1):
  - RW←1, DOUT_OE←0, busy←0.
  - ack←1 for one clk32; berr←error flag.
  - The wait counter clears.
- A new request is never captured on the same en1 that ends S7. The earliest S0 is the following en1, 4 clk32 later.
- bus_free is checked only in IDLE. Loss of bus_free mid-cycle is ignored.

## Timing
- Reset values: AS_N=UDS_N=LDS_N=RW=1, DOUT_OE=0, A=0, FC=0, DOUT=0, rdata=0, busy=ack=berr=0, state IDLE, wait counter 0.
- Reset asserted mid-cycle negates all strobes and DOUT_OE immediately and produces no ack.
- Zero-wait cycle: 8 half-states, 16 clk32 from the capture en1 to the ack edge.
- Each wait pair adds 4 clk32.
- Strobe low time (read, zero wait): AS_N from S2 to S7 is 10 clk32. Write UDS_N/LDS_N are low for 6 clk32.
- DTACK_N asserted after the S4→S5 sample point extends the cycle by exactly one wait pair.
- DTACK_N and BERR_N both low at the sample: berr=1.
- Wait-counter width is clog2(TIMEOUT+1). It saturates and never wraps.
- mhz8_en1 and mhz8_en2 are never high in the same clk32. If they are, the block must ignore both.

## Test plan
- Read word, addr=0x7FFFF, DTACK_N tied low, DIN=0x1234 → AS_N low 10 clk32, UDS_N=LDS_N=0, ack 16 clk32 after capture, rdata=0x1234, berr=0.
- Write byte, lbe only, wdata=0x00A5, DTACK_N low → UDS_N stays 1, LDS_N low 6 clk32, DOUT_OE high S3–S7, DOUT=0x00A5, RW=0 until ack.
- Read with DTACK_N asserted 3 MHZ8 periods late → 3 wait pairs, ack at 28 clk32, correct rdata.
- No DTACK_N/BERR_N, TIMEOUT=4 → ack with berr=1 at 16+16 clk32, rdata unchanged.
- bus_free=0 while req=1 → no strobes. Raise bus_free → S0 on the next en1.
- reset pulse during S5 → strobes high the same clk32, no ack. The next request completes normally.
